if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_if.sv | 26 ++
 rtl/if_prefetch.sv | 98 +++++++++
 tb/tb_if_prefetch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// Bundle of the fetch-side memory handshake and the decode-side queue handshake
// of the instruction prefetch unit; master is the prefetch unit itself.
interface if_prefetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_ir_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_npc_o;

    modport master (
        output imem_req_o, imem_addr_o, id_valid_o, id_ir_o, id_pc_o, id_npc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, id_valid_o, id_ir_o, id_pc_o, id_npc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: issues sequential word fetches, tracks in-flight
// requests, drops stale responses after a redirect and queues {ir, pc} for ID.
module if_prefetch #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_prefetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] pc_reg;
    logic [31:0] resp_pc_reg;
    logic [2:0]  outst_reg;
    logic [2:0]  drop_reg;
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    logic [31:0] ir_mem [DEPTH];
    logic [31:0] pc_mem [DEPTH];

    logic [AW:0] count;
    logic [5:0]  occupancy;
    logic        empty;
    logic        full;
    logic        req;
    logic        grant;
    logic        rsp;
    logic        wr_en;
    logic        pop;
    logic [31:0] target;

    assign count     = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Every in-flight request (including ones to be dropped) holds a queue slot.
    assign occupancy = 6'(count) + 6'(outst_reg);
    assign req       = !rst_i && !bus.redirect_i &&
                       (outst_reg < 3'(MAX_OUTST)) && (occupancy < 6'(DEPTH));
    assign grant     = req && bus.imem_gnt_i;
    // Responses with nothing outstanding belong to requests abandoned by reset.
    assign rsp       = bus.imem_rvalid_i && (outst_reg != 3'd0);
    assign wr_en     = rsp && (drop_reg == 3'd0) && !bus.redirect_i && !full;
    assign pop       = !empty && bus.id_ready_i && !bus.redirect_i;
    assign target    = bus.redirect_pc_i & 32'hFFFF_FFFC;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_reg      <= RESET_PC;
            resp_pc_reg <= RESET_PC;
            outst_reg   <= 3'd0;
            drop_reg    <= 3'd0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
        end else begin
            outst_reg <= outst_reg + 3'(grant) - 3'(rsp);
            if (bus.redirect_i) begin
                drop_reg    <= outst_reg - 3'(rsp);
                pc_reg      <= target;
                resp_pc_reg <= target;
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
            end else begin
                if (grant) begin
                    pc_reg <= pc_reg + 32'd4;
                end
                if (rsp && (drop_reg != 3'd0)) begin
                    drop_reg <= drop_reg - 3'd1;
                end
                if (wr_en) begin
                    wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                    resp_pc_reg <= resp_pc_reg + 32'd4;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    end

    // Queue storage carries no reset; the outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ir_mem[wr_ptr_reg[AW-1:0]] <= bus.imem_rdata_i;
            pc_mem[wr_ptr_reg[AW-1:0]] <= resp_pc_reg;
        end
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_reg;
    assign bus.id_valid_o  = !empty;
    assign bus.id_ir_o     = empty ? 32'd0 : ir_mem[rd_ptr_reg[AW-1:0]];
    assign bus.id_pc_o     = empty ? 32'd0 : pc_mem[rd_ptr_reg[AW-1:0]];
    assign bus.id_npc_o    = empty ? 32'd0 : pc_mem[rd_ptr_reg[AW-1:0]] + 32'd4;
endmodule

// File: tb/tb_if_prefetch.sv
// Directed and random stimulus for if_prefetch against a queue-based model of
// in-flight requests and the ID queue.
module tb_if_prefetch;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
    } req_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_if bus ();

    if_prefetch #(
        .DEPTH    (DEPTH),
        .MAX_OUTST(MAX_OUTST),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    req_t        inflight[$];
    ins_t        idq[$];
    logic [31:0] m_pc = RESET_PC;
    int          tests = 0;
    int          fails = 0;
    int          grants = 0;
    bit          want_first = 1'b0;
    logic [31:0] want_pc = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit gnt, input bit rv, input bit rdy, input bit rd,
                        input logic [31:0] rpc, input bit stale);
        bit   exp_req;
        bit   exp_valid;
        bit   do_rv;
        req_t e;
        ins_t w;
        do_rv = rv && (inflight.size() > 0) && !rst;
        bus.imem_gnt_i    = gnt;
        bus.imem_rvalid_i = do_rv || stale;
        bus.imem_rdata_i  = do_rv ? mem_word(inflight[0].addr) : 32'hDEAD_BEEF;
        bus.id_ready_i    = rdy;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        #1;
        if (rst) begin
            chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
            chk("rst_valid", {31'd0, bus.id_valid_o}, 32'd0);
            chk("rst_ir", bus.id_ir_o, 32'd0);
            chk("rst_pc", bus.id_pc_o, 32'd0);
            chk("rst_npc", bus.id_npc_o, 32'd0);
            inflight.delete();
            idq.delete();
            m_pc = RESET_PC;
        end else begin
            exp_req = !rd && (inflight.size() < MAX_OUTST) &&
                      (idq.size() + inflight.size() < DEPTH);
            chk("imem_req", {31'd0, bus.imem_req_o}, {31'd0, exp_req});
            if (exp_req) chk("imem_addr", bus.imem_addr_o, m_pc);
            exp_valid = (idq.size() > 0);
            chk("id_valid", {31'd0, bus.id_valid_o}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("id_pc", bus.id_pc_o, idq[0].pc);
                chk("id_ir", bus.id_ir_o, idq[0].ir);
                chk("id_npc", bus.id_npc_o, idq[0].pc + 32'd4);
                if (want_first) chk("first_pc", bus.id_pc_o, want_pc);
                want_first = 1'b0;
            end
            if (exp_valid && rdy && !rd) void'(idq.pop_front());
            if (do_rv) begin
                e = inflight.pop_front();
                if (e.keep && !rd) begin
                    w.ir = mem_word(e.addr);
                    w.pc = e.addr;
                    idq.push_back(w);
                end
            end
            if (exp_req && gnt) begin
                e.addr = m_pc;
                e.keep = 1'b1;
                inflight.push_back(e);
                m_pc = m_pc + 32'd4;
                grants++;
            end
            if (rd) begin
                idq.delete();
                for (int i = 0; i < inflight.size(); i++) inflight[i].keep = 1'b0;
                m_pc = rpc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_first(input logic [31:0] pc);
        want_first = 1'b1;
        want_pc    = pc;
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'd0;
        bus.id_ready_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        @(negedge clk);
        repeat (3) step(1, 1, 1, 0, 32'd0, 0);
        rst = 1'b0;

        // Streaming from reset across the 32-bit wrap, one instruction per cycle.
        expect_first(RESET_PC);
        repeat (14) step(1, 1, 1, 0, 32'd0, 0);

        // Stalled ID: the queue reservation allows exactly DEPTH grants.
        repeat (4) step(0, 1, 1, 0, 32'd0, 0);
        grants = 0;
        repeat (10) step(1, 1, 0, 0, 32'd0, 0);
        chk("grants_full", grants, DEPTH);
        repeat (10) step(1, 1, 1, 0, 32'd0, 0);

        // Two requests in flight, redirect; both stale responses are dropped.
        repeat (4) step(0, 1, 1, 0, 32'd0, 0);
        repeat (2) step(1, 0, 1, 0, 32'd0, 0);
        step(0, 0, 1, 1, 32'h0000_0103, 0);
        expect_first(32'h0000_0100);
        repeat (10) step(1, 1, 1, 0, 32'd0, 0);

        // Redirect coincident with a pop and a response.
        repeat (3) step(1, 1, 0, 0, 32'd0, 0);
        step(0, 1, 1, 1, 32'h0000_0400, 0);
        expect_first(32'h0000_0400);
        repeat (8) step(1, 1, 1, 0, 32'd0, 0);

        // Back-to-back redirects; the last target wins.
        step(1, 1, 1, 1, 32'h0000_0200, 0);
        step(1, 1, 1, 1, 32'h0000_0300, 0);
        expect_first(32'h0000_0300);
        repeat (8) step(1, 1, 1, 0, 32'd0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 32'($urandom), 0);
        end

        // Reset with two outstanding, then late responses after release.
        repeat (4) step(0, 1, 1, 0, 32'd0, 0);
        repeat (2) step(1, 0, 1, 0, 32'd0, 0);
        rst = 1'b1;
        repeat (2) step(0, 0, 1, 0, 32'd0, 0);
        rst = 1'b0;
        repeat (3) step(0, 0, 1, 0, 32'd0, 1);
        expect_first(RESET_PC);
        repeat (10) step(1, 1, 1, 0, 32'd0, 0);
        chk("first_pc_seen", {31'd0, want_first}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
